// File: rtl/boom_seq_pkg.sv
// Shared state encodings and defaults for the BOOM boot sequencer.
package boom_seq_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_EN_WAIT   = 3'd1;
    localparam logic [2:0] ST_BOOT_INT  = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_STOP_WAIT = 3'd4;
    localparam logic [2:0] ST_FAULT     = 3'd5;

    localparam int unsigned STOP_CYCLES_DEF = 4;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/boom_seq_cnt.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module boom_seq_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/boom_boot_seq.sv
// BOOM core boot sequencer: enable, delayed boot interrupt, run, quiesce on stop,
// and latch into FAULT when memory error status moves away from its boot snapshot.
module boom_boot_seq
    import boom_seq_pkg::*;
#(
    parameter int unsigned EN_DELAY_W  = 16,
    parameter int unsigned INT_LEN_W   = 8,
    parameter int unsigned STOP_CYCLES = STOP_CYCLES_DEF
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  clear_i,
    input  logic [EN_DELAY_W-1:0] cfg_en_delay_i,
    input  logic [INT_LEN_W-1:0]  cfg_int_len_i,
    input  logic [31:0]           tcu_mem_axi4_error_i,
    input  logic [31:0]           axi4_mem_bridge_error_i,
    output logic                  boom_en_o,
    output logic                  boom_ext_int1_o,
    output logic                  running_o,
    output logic                  fault_o,
    output logic [2:0]            state_o
);

    localparam int unsigned CNT_W_RAW = max3(EN_DELAY_W, INT_LEN_W, $clog2(STOP_CYCLES + 1));
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] STOP_LOAD = (STOP_CYCLES > 0) ? CNT_W'(STOP_CYCLES - 1) : '0;

    logic [2:0]           state_q, state_d;
    logic [INT_LEN_W-1:0] int_len_q;
    logic [31:0]          tcu_snap_q, br_snap_q;
    logic                 snap_en;
    logic                 err_chg;
    logic                 cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]     cnt_val;
    logic [CNT_W-1:0]     boot_load;

    // Counter holds "cycles remaining minus one", so a zero load gives a one-cycle state.
    assign boot_load = (int_len_q == '0) ? '0 : CNT_W'(int_len_q - INT_LEN_W'(1));
    assign err_chg   = (tcu_mem_axi4_error_i != tcu_snap_q) ||
                       (axi4_mem_bridge_error_i != br_snap_q);

    boom_seq_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load      (cnt_load),
        .load_val  (cnt_val),
        .dec       (cnt_dec),
        .zero      (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        snap_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_EN_WAIT;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(cfg_en_delay_i);
                    snap_en  = 1'b1;
                end
            end
            ST_EN_WAIT, ST_BOOT_INT: begin
                if (err_chg) begin
                    state_d = ST_FAULT;
                end else if (stop_i) begin
                    state_d  = ST_STOP_WAIT;
                    cnt_load = 1'b1;
                    cnt_val  = STOP_LOAD;
                end else if (cnt_zero) begin
                    if (state_q == ST_EN_WAIT) begin
                        state_d  = ST_BOOT_INT;
                        cnt_load = 1'b1;
                        cnt_val  = boot_load;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RUN: begin
                if (err_chg) begin
                    state_d = ST_FAULT;
                end else if (stop_i) begin
                    state_d  = ST_STOP_WAIT;
                    cnt_load = 1'b1;
                    cnt_val  = STOP_LOAD;
                end
            end
            ST_STOP_WAIT: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_FAULT: begin
                if (clear_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            int_len_q  <= '0;
            tcu_snap_q <= '0;
            br_snap_q  <= '0;
        end else begin
            state_q <= state_d;
            if (snap_en) begin
                int_len_q  <= cfg_int_len_i;
                tcu_snap_q <= tcu_mem_axi4_error_i;
                br_snap_q  <= axi4_mem_bridge_error_i;
            end
        end
    end

    // Outputs are separate flops decoded from the next state to stay Moore and glitch-free.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            boom_en_o       <= 1'b0;
            boom_ext_int1_o <= 1'b0;
            running_o       <= 1'b0;
            fault_o         <= 1'b0;
        end else begin
            boom_en_o       <= (state_d == ST_EN_WAIT) || (state_d == ST_BOOT_INT) ||
                               (state_d == ST_RUN);
            boom_ext_int1_o <= (state_d == ST_BOOT_INT);
            running_o       <= (state_d == ST_RUN);
            fault_o         <= (state_d == ST_FAULT);
        end
    end

    assign state_o = state_q;

endmodule

// File: doc/boom_boot_seq.md
BOOM_BOOT_SEQ -- requirements
Module: boom_boot_seq

Interface
REQ-001 SHALL have parameter EN_DELAY_W, default 16, width of enable-to-boot delay.
REQ-002 SHALL have parameter INT_LEN_W, default 8, width of boot-interrupt pulse length.
REQ-003 SHALL have parameter STOP_CYCLES, default 4, quiesce cycles after disable.
REQ-004 SHALL have port clk_i  in  1  clock, rising edge.
REQ-005 SHALL have port reset_n_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_i  in  1  one-cycle boot request.
REQ-007 SHALL have port stop_i  in  1  one-cycle shutdown request.
REQ-008 SHALL have port clear_i  in  1  one-cycle fault acknowledge.
REQ-009 SHALL have port cfg_en_delay_i  in  EN_DELAY_W  cycles between enable and boot interrupt.
REQ-010 SHALL have port cfg_int_len_i  in  INT_LEN_W  boot-interrupt pulse length.
REQ-011 SHALL have port tcu_mem_axi4_error_i  in  32  TCU memory AXI4 error status.
REQ-012 SHALL have port axi4_mem_bridge_error_i  in  32  memory bridge error status.
REQ-013 SHALL have port boom_en_o  out  1  core enable.
REQ-014 SHALL have port boom_ext_int1_o  out  1  boot interrupt.
REQ-015 SHALL have port running_o  out  1  high in RUN.
REQ-016 SHALL have port fault_o  out  1  high in FAULT.
REQ-017 SHALL have port state_o  out  3  current state encoding.

Function
REQ-018 SHALL implement states IDLE=0, EN_WAIT=1, BOOT_INT=2, RUN=3, STOP_WAIT=4, FAULT=5; codes 6-7 SHALL return to IDLE.
REQ-019 SHALL drive all outputs from registers (Moore); boom_en_o=1 in EN_WAIT, BOOT_INT, RUN; boom_ext_int1_o=1 only in BOOT_INT.
REQ-020 IDLE: start_i -> EN_WAIT next cycle; latch cfg_en_delay_i, cfg_int_len_i and both error inputs (snapshot) on that edge.
REQ-021 EN_WAIT SHALL last latched delay+1 cycles (delay 0 -> 1 cycle), then BOOT_INT.
REQ-022 BOOT_INT SHALL last max(latched int_len,1) cycles, then RUN.
REQ-023 RUN: stop_i -> STOP_WAIT; STOP_WAIT SHALL last STOP_CYCLES cycles with boom_en_o=0, then IDLE.
REQ-024 In EN_WAIT/BOOT_INT/RUN, either error input differing from its snapshot SHALL -> FAULT next cycle.
REQ-025 FAULT: boom_en_o=0, fault_o=1; only clear_i -> IDLE.
REQ-026 Priority when simultaneous: fault > stop > state-counter expiry; stop_i in EN_WAIT/BOOT_INT SHALL also -> STOP_WAIT.
REQ-027 start_i outside IDLE, stop_i in IDLE/STOP_WAIT/FAULT, and clear_i outside FAULT SHALL be ignored.
REQ-028 Config inputs changing after start SHALL not affect the running sequence.
REQ-029 Down-counter width SHALL be max(EN_DELAY_W,INT_LEN_W,clog2(STOP_CYCLES+1)); no wrap-around permitted.

Reset
REQ-030 reset_n_i low SHALL asynchronously force IDLE, counter 0, snapshots 0, all outputs 0, state_o=0.
REQ-031 Reset mid-sequence SHALL drop boom_en_o and boom_ext_int1_o immediately, without a STOP_WAIT.

Structure
REQ-032 State encodings and STOP_CYCLES default SHALL live in shared package boom_seq_pkg.
REQ-033 Single module; one sub-module boom_seq_cnt (loadable down-counter with zero flag) permitted.

Verification
REQ-034 delay=3, int_len=2, start at cycle 0 -> boom_en_o high cycles 1..; int1 high cycles 5-6; running_o from cycle 7.
REQ-035 delay=0, int_len=0 -> EN_WAIT 1 cycle, int1 high exactly 1 cycle, then RUN.
REQ-036 RUN, stop_i -> boom_en_o low next cycle, state_o=4 for 4 cycles, then 0.
REQ-037 RUN, bridge error 0->0x1 -> fault_o=1, boom_en_o=0 next cycle; start_i ignored; clear_i -> IDLE.
REQ-038 stop_i and error change same cycle in BOOT_INT -> FAULT (state_o=5).
REQ-039 reset_n_i low in BOOT_INT -> outputs 0 asynchronously; after release start_i boots normally.
